// File: rtl/ram_port_arbiter.sv
// Shares one single-ported RAM between IF fetch and MEM load/store with fixed wait states.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed MEM>IF priority.
module ram_port_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  input  logic              MEM_Req,
  input  logic [ADDR_W-1:0] MEM_Addr,
  input  logic              MEM_RW,
  input  logic [1:0]        MEM_Size,
  input  logic              MEM_SE,
  input  logic [31:0]       MEM_WData,
  input  logic [31:0]       RAM_DataOut,
  output logic              RAM_Enable,
  output logic              RAM_RW,
  output logic              RAM_SE,
  output logic [1:0]        RAM_Size,
  output logic [ADDR_W-1:0] RAM_Addr,
  output logic [31:0]       RAM_DataIn,
  output logic              IF_Done,
  output logic [31:0]       IF_Data,
  output logic              MEM_Done,
  output logic [31:0]       MEM_RData,
  output logic              Align_Err,
  output logic              Pipe_Stall
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_IF  = 2'd1,
    ACC_MEM = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_rw_q, ram_rw_d;
  logic                ram_se_q, ram_se_d;
  logic [1:0]          ram_size_q, ram_size_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                if_done_q, if_done_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic                mem_done_q, mem_done_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                align_err_q, align_err_d;

  logic if_elig, mem_elig, grant_mem, mem_misaligned, acc_last;

  // A requester whose Done is showing this cycle holds a stale Req.
  assign if_elig  = IF_Req  & ~if_done_q;
  assign mem_elig = MEM_Req & ~mem_done_q;
  assign acc_last = (cnt_q == CNT_W'(WAIT_STATES));

  always_comb begin
    unique case (MEM_Size)
      2'b00:   mem_misaligned = 1'b0;
      2'b01:   mem_misaligned = MEM_Addr[0];
      2'b10:   mem_misaligned = |MEM_Addr[1:0];
      default: mem_misaligned = 1'b1;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_if_q, last_if_d;

  // On contention, serve whoever did not complete last.
  assign grant_mem = mem_elig & (~if_elig | last_if_q);
`else
  assign grant_mem = mem_elig;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_en_d    = ram_en_q;
    ram_rw_d    = ram_rw_q;
    ram_se_d    = ram_se_q;
    ram_size_d  = ram_size_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    align_err_d = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_if_d   = last_if_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_mem) begin
          if (mem_misaligned) begin
            state_d     = DONE;
            mem_done_d  = 1'b1;
            align_err_d = 1'b1;
            mem_rdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_if_d   = 1'b0;
`endif
          end else begin
            state_d     = ACC_MEM;
            ram_en_d    = 1'b1;
            ram_rw_d    = MEM_RW;
            ram_se_d    = MEM_SE;
            ram_size_d  = MEM_Size;
            ram_addr_d  = MEM_Addr;
            ram_wdata_d = MEM_RW ? MEM_WData : '0;
          end
        end else if (if_elig) begin
          state_d     = ACC_IF;
          ram_en_d    = 1'b1;
          ram_rw_d    = 1'b0;
          ram_se_d    = 1'b0;
          ram_size_d  = 2'b10;
          ram_addr_d  = IF_Addr;
          ram_wdata_d = '0;
        end
      end

      ACC_IF, ACC_MEM: begin
        if (acc_last) begin
          state_d     = DONE;
          cnt_d       = '0;
          ram_en_d    = 1'b0;
          ram_rw_d    = 1'b0;
          ram_se_d    = 1'b0;
          ram_size_d  = '0;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
          if (state_q == ACC_IF) begin
            if_done_d = 1'b1;
            if_data_d = RAM_DataOut;
`ifdef ARB_ROUND_ROBIN_EN
            last_if_d = 1'b1;
`endif
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = ram_rw_q ? '0 : RAM_DataOut;
`ifdef ARB_ROUND_ROBIN_EN
            last_if_d   = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        ram_en_d    = 1'b0;
        ram_rw_d    = 1'b0;
        ram_se_d    = 1'b0;
        ram_size_d  = '0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_se_q    <= 1'b0;
      ram_size_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_se_q    <= ram_se_d;
      ram_size_q  <= ram_size_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      align_err_q <= align_err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset to "IF served last" so MEM wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_if_q <= 1'b1;
    end else begin
      last_if_q <= last_if_d;
    end
  end
`endif

  assign RAM_Enable = ram_en_q;
  assign RAM_RW     = ram_rw_q;
  assign RAM_SE     = ram_se_q;
  assign RAM_Size   = ram_size_q;
  assign RAM_Addr   = ram_addr_q;
  assign RAM_DataIn = ram_wdata_q;
  assign IF_Done    = if_done_q;
  assign IF_Data    = if_data_q;
  assign MEM_Done   = mem_done_q;
  assign MEM_RData  = mem_rdata_q;
  assign Align_Err  = align_err_q;
  assign Pipe_Stall = (IF_Req & ~if_done_q) | (MEM_Req & ~mem_done_q);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter at WAIT_STATES=1; expectations follow the RR macro if set.
module tb_ram_port_arbiter;

  localparam int unsigned ADDR_W = 9;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              IF_Req;
  logic [ADDR_W-1:0] IF_Addr;
  logic              MEM_Req;
  logic [ADDR_W-1:0] MEM_Addr;
  logic              MEM_RW;
  logic [1:0]        MEM_Size;
  logic              MEM_SE;
  logic [31:0]       MEM_WData;
  logic [31:0]       RAM_DataOut;
  logic              RAM_Enable, RAM_RW, RAM_SE;
  logic [1:0]        RAM_Size;
  logic [ADDR_W-1:0] RAM_Addr;
  logic [31:0]       RAM_DataIn;
  logic              IF_Done, MEM_Done, Align_Err, Pipe_Stall;
  logic [31:0]       IF_Data, MEM_RData;

  int vectors     = 0;
  int miscompares = 0;

  wire [45:0]  ram_bus = {RAM_Enable, RAM_RW, RAM_SE, RAM_Size, RAM_Addr, RAM_DataIn};
  wire [113:0] all_out = {ram_bus, IF_Done, IF_Data, MEM_Done, MEM_RData, Align_Err, Pipe_Stall};

  always #5 clk = ~clk;

  ram_port_arbiter #(.WAIT_STATES(1), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr),
    .MEM_Req(MEM_Req), .MEM_Addr(MEM_Addr), .MEM_RW(MEM_RW), .MEM_Size(MEM_Size),
    .MEM_SE(MEM_SE), .MEM_WData(MEM_WData), .RAM_DataOut(RAM_DataOut),
    .RAM_Enable(RAM_Enable), .RAM_RW(RAM_RW), .RAM_SE(RAM_SE), .RAM_Size(RAM_Size),
    .RAM_Addr(RAM_Addr), .RAM_DataIn(RAM_DataIn),
    .IF_Done(IF_Done), .IF_Data(IF_Data), .MEM_Done(MEM_Done), .MEM_RData(MEM_RData),
    .Align_Err(Align_Err), .Pipe_Stall(Pipe_Stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; IF_Req = 1'b0; IF_Addr = '0; MEM_Req = 1'b0; MEM_Addr = '0;
    MEM_RW = 1'b0; MEM_Size = 2'b00; MEM_SE = 1'b0; MEM_WData = '0; RAM_DataOut = '0;
    tick(); tick();
    vectors++;
    if (all_out !== 114'h0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_if_fetch();
    IF_Addr = 9'h010; IF_Req = 1'b1; RAM_DataOut = 32'h1111_1111;
    #1;
    vectors++;
    if ({RAM_Enable, Pipe_Stall} !== 2'b01) begin
      miscompares++; $display("FAIL if_c0: got en/stall %b expected 01", {RAM_Enable, Pipe_Stall});
    end
    tick();
    vectors++;
    if ({ram_bus, Pipe_Stall} !== {1'b1, 1'b0, 1'b0, 2'b10, 9'h010, 32'h0, 1'b1}) begin
      miscompares++; $display("FAIL if_c1_ram: got %h", {ram_bus, Pipe_Stall});
    end
    RAM_DataOut = 32'h8A00_0001;
    tick();
    vectors++;
    if ({ram_bus, IF_Done, Pipe_Stall} !== {1'b1, 1'b0, 1'b0, 2'b10, 9'h010, 32'h0, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL if_c2_ram: got %h", {ram_bus, IF_Done, Pipe_Stall});
    end
    tick();
    vectors++;
    if ({ram_bus, IF_Done, IF_Data, Pipe_Stall} !== {46'h0, 1'b1, 32'h8A00_0001, 1'b0}) begin
      miscompares++; $display("FAIL if_c3_done: got done %b data %h stall %b en %b expected 1 8a000001 0 0",
                              IF_Done, IF_Data, Pipe_Stall, RAM_Enable);
    end
    IF_Req = 1'b0; RAM_DataOut = 32'h0;
    tick();
    vectors++;
    if ({IF_Done, IF_Data} !== {1'b0, 32'h8A00_0001}) begin
      miscompares++; $display("FAIL if_c4_hold: got done %b data %h expected 0 8a000001", IF_Done, IF_Data);
    end
  endtask

  task automatic test_mem_store();
    MEM_Addr = 9'h004; MEM_RW = 1'b1; MEM_Size = 2'b10; MEM_SE = 1'b0;
    MEM_WData = 32'hDEAD_BEEF; MEM_Req = 1'b1; RAM_DataOut = 32'hFFFF_FFFF;
    tick();
    vectors++;
    if (ram_bus !== {1'b1, 1'b1, 1'b0, 2'b10, 9'h004, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL store_c1_ram: got %h", ram_bus);
    end
    tick();
    vectors++;
    if ({ram_bus, MEM_Done} !== {1'b1, 1'b1, 1'b0, 2'b10, 9'h004, 32'hDEAD_BEEF, 1'b0}) begin
      miscompares++; $display("FAIL store_c2_ram: got %h", {ram_bus, MEM_Done});
    end
    tick();
    vectors++;
    if ({RAM_Enable, MEM_Done, Align_Err, MEM_RData, Pipe_Stall} !== {1'b0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++; $display("FAIL store_c3_done: got en %b done %b aerr %b rdata %h stall %b expected 0 1 0 0 0",
                              RAM_Enable, MEM_Done, Align_Err, MEM_RData, Pipe_Stall);
    end
    MEM_Req = 1'b0; MEM_RW = 1'b0;
    tick();
    vectors++;
    if ({MEM_Done, RAM_Enable} !== 2'b00) begin
      miscompares++; $display("FAIL store_c4_idle: got done/en %b expected 00", {MEM_Done, RAM_Enable});
    end
  endtask

  task automatic test_mem_load_drop();
    MEM_Addr = 9'h006; MEM_RW = 1'b0; MEM_Size = 2'b01; MEM_SE = 1'b1;
    MEM_WData = 32'h1234_5678; MEM_Req = 1'b1; RAM_DataOut = 32'hFFFF_FFFF;
    tick();
    vectors++;
    if (ram_bus !== {1'b1, 1'b0, 1'b1, 2'b01, 9'h006, 32'h0}) begin
      miscompares++; $display("FAIL load_c1_ram: got %h", ram_bus);
    end
    MEM_Req = 1'b0; MEM_Addr = 9'h1FF; MEM_SE = 1'b0; RAM_DataOut = 32'h0000_FF80;
    tick();
    vectors++;
    if ({ram_bus, Pipe_Stall} !== {1'b1, 1'b0, 1'b1, 2'b01, 9'h006, 32'h0, 1'b0}) begin
      miscompares++; $display("FAIL load_c2_dropped: got %h", {ram_bus, Pipe_Stall});
    end
    tick();
    vectors++;
    if ({MEM_Done, Align_Err, MEM_RData} !== {1'b1, 1'b0, 32'h0000_FF80}) begin
      miscompares++; $display("FAIL load_c3_done: got done %b aerr %b rdata %h expected 1 0 0000ff80",
                              MEM_Done, Align_Err, MEM_RData);
    end
    tick();
  endtask

  task automatic test_misalign();
    logic [1:0]        sz [3] = '{2'b01, 2'b10, 2'b11};
    logic [ADDR_W-1:0] ad [3] = '{9'h003, 9'h002, 9'h000};
    for (int i = 0; i < 3; i++) begin
      MEM_Size = sz[i]; MEM_Addr = ad[i]; MEM_RW = 1'b0; MEM_Req = 1'b1;
      RAM_DataOut = 32'h7777_7777;
      tick();
      vectors++;
      if ({RAM_Enable, MEM_Done, Align_Err, MEM_RData, Pipe_Stall} !== {1'b0, 1'b1, 1'b1, 32'h0, 1'b0}) begin
        miscompares++; $display("FAIL misalign_%0d: got en %b done %b aerr %b rdata %h stall %b expected 0 1 1 0 0",
                                i, RAM_Enable, MEM_Done, Align_Err, MEM_RData, Pipe_Stall);
      end
      MEM_Req = 1'b0;
      tick();
      vectors++;
      if ({RAM_Enable, MEM_Done, Align_Err} !== 3'b000) begin
        miscompares++; $display("FAIL misalign_%0d_after: got %b expected 000", i, {RAM_Enable, MEM_Done, Align_Err});
      end
    end
  endtask

  task automatic test_priority();
    logic [ADDR_W-1:0] first_addr  = RR ? 9'h020 : 9'h008;
    logic [ADDR_W-1:0] second_addr = RR ? 9'h008 : 9'h020;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    // First contention: MEM wins in both arbitration modes.
    IF_Addr = 9'h020; MEM_Addr = 9'h008; MEM_Size = 2'b10; MEM_RW = 1'b0; MEM_SE = 1'b0;
    IF_Req = 1'b1; MEM_Req = 1'b1; RAM_DataOut = 32'hAAAA_0001;
    tick();
    vectors++;
    if ({RAM_Enable, RAM_Addr} !== {1'b1, 9'h008}) begin
      miscompares++; $display("FAIL pri1_c1: got en %b addr %h expected 1 008", RAM_Enable, RAM_Addr);
    end
    tick();
    tick();
    vectors++;
    if ({MEM_Done, IF_Done, MEM_RData, Pipe_Stall} !== {1'b1, 1'b0, 32'hAAAA_0001, 1'b1}) begin
      miscompares++; $display("FAIL pri1_c3: got mdone %b idone %b rdata %h stall %b expected 1 0 aaaa0001 1",
                              MEM_Done, IF_Done, MEM_RData, Pipe_Stall);
    end
    MEM_Req = 1'b0; RAM_DataOut = 32'hBBBB_0002;
    tick();
    vectors++;
    if (RAM_Enable !== 1'b0) begin
      miscompares++; $display("FAIL pri1_c4_gap: got en %b expected 0", RAM_Enable);
    end
    tick();
    vectors++;
    if ({RAM_Enable, RAM_RW, RAM_Addr} !== {1'b1, 1'b0, 9'h020}) begin
      miscompares++; $display("FAIL pri1_c5: got en %b rw %b addr %h expected 1 0 020", RAM_Enable, RAM_RW, RAM_Addr);
    end
    tick();
    tick();
    vectors++;
    if ({IF_Done, IF_Data, MEM_Done} !== {1'b1, 32'hBBBB_0002, 1'b0}) begin
      miscompares++; $display("FAIL pri1_c7: got idone %b data %h mdone %b expected 1 bbbb0002 0",
                              IF_Done, IF_Data, MEM_Done);
    end
    IF_Req = 1'b0;
    tick();
    // Lone MEM access so the last completion is MEM.
    MEM_Addr = 9'h00C; MEM_Req = 1'b1; RAM_DataOut = 32'hCCCC_0003;
    tick(); tick(); tick();
    vectors++;
    if ({MEM_Done, MEM_RData} !== {1'b1, 32'hCCCC_0003}) begin
      miscompares++; $display("FAIL lone_mem_done: got %b %h expected 1 cccc0003", MEM_Done, MEM_RData);
    end
    MEM_Req = 1'b0;
    tick();
    // Second contention: fixed priority picks MEM, round-robin picks IF.
    IF_Addr = 9'h020; MEM_Addr = 9'h008; IF_Req = 1'b1; MEM_Req = 1'b1;
    tick();
    vectors++;
    if ({RAM_Enable, RAM_Addr} !== {1'b1, first_addr}) begin
      miscompares++; $display("FAIL pri2_c1: got en %b addr %h expected 1 %h", RAM_Enable, RAM_Addr, first_addr);
    end
    tick(); tick();
    vectors++;
    if ({IF_Done, MEM_Done} !== (RR ? 2'b10 : 2'b01)) begin
      miscompares++; $display("FAIL pri2_c3: got if/mem done %b expected %b", {IF_Done, MEM_Done}, RR ? 2'b10 : 2'b01);
    end
    if (RR) IF_Req = 1'b0; else MEM_Req = 1'b0;
    tick(); tick();
    vectors++;
    if ({RAM_Enable, RAM_Addr} !== {1'b1, second_addr}) begin
      miscompares++; $display("FAIL pri2_c5: got en %b addr %h expected 1 %h", RAM_Enable, RAM_Addr, second_addr);
    end
    tick(); tick();
    vectors++;
    if ({IF_Done, MEM_Done} !== (RR ? 2'b01 : 2'b10)) begin
      miscompares++; $display("FAIL pri2_c7: got if/mem done %b expected %b", {IF_Done, MEM_Done}, RR ? 2'b01 : 2'b10);
    end
    IF_Req = 1'b0; MEM_Req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    IF_Addr = 9'h030; IF_Req = 1'b1; RAM_DataOut = 32'h5555_AAAA;
    tick(); tick();
    vectors++;
    if (RAM_Enable !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_c2_pre: got en %b expected 1", RAM_Enable);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({RAM_Enable, IF_Done, IF_Data, Pipe_Stall} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      miscompares++; $display("FAIL rstmid_async: got en %b done %b data %h stall %b expected 0 0 0 1",
                              RAM_Enable, IF_Done, IF_Data, Pipe_Stall);
    end
    tick();
    vectors++;
    if ({RAM_Enable, IF_Done} !== 2'b00) begin
      miscompares++; $display("FAIL rstmid_held: got en/done %b expected 00", {RAM_Enable, IF_Done});
    end
    rst_n = 1'b1; RAM_DataOut = 32'h1357_9BDF;
    tick();
    vectors++;
    if ({RAM_Enable, RAM_Addr, IF_Done} !== {1'b1, 9'h030, 1'b0}) begin
      miscompares++; $display("FAIL rstmid_restart: got en %b addr %h done %b expected 1 030 0",
                              RAM_Enable, RAM_Addr, IF_Done);
    end
    tick(); tick();
    vectors++;
    if ({IF_Done, IF_Data} !== {1'b1, 32'h1357_9BDF}) begin
      miscompares++; $display("FAIL rstmid_done: got %b %h expected 1 13579bdf", IF_Done, IF_Data);
    end
    IF_Req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    IF_Addr = 9'h040; IF_Req = 1'b1; RAM_DataOut = 32'h2468_ACE0;
    tick(); tick(); tick();
    vectors++;
    if ({IF_Done, IF_Data, Pipe_Stall} !== {1'b1, 32'h2468_ACE0, 1'b0}) begin
      miscompares++; $display("FAIL held_c3_done: got done %b data %h stall %b expected 1 2468ace0 0",
                              IF_Done, IF_Data, Pipe_Stall);
    end
    tick();
    vectors++;
    if ({RAM_Enable, IF_Done} !== 2'b00) begin
      miscompares++; $display("FAIL held_c4_no_regrant: got en/done %b expected 00", {RAM_Enable, IF_Done});
    end
    IF_Req = 1'b0;
    tick();
    vectors++;
    if ({RAM_Enable, IF_Done, Pipe_Stall} !== 3'b000) begin
      miscompares++; $display("FAIL held_c5_idle: got %b expected 000", {RAM_Enable, IF_Done, Pipe_Stall});
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_mem_store();
    test_mem_load_drop();
    test_misalign();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
